// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Bit positions within the status word.
    localparam int unsigned BUSY  = 0;
    localparam int unsigned EMPTY = 1;
    localparam int unsigned FULL  = 2;
    localparam int unsigned OVF   = 3;

    localparam logic [31:0] DEF_TX_DATA_ADDR = 32'h1001_0024;
    localparam logic [31:0] DEF_STATUS_ADDR  = 32'h1001_0028;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous circular-buffer FIFO.
// Full and empty are judged from the registered count, before this cycle's pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/port_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, status/overflow and
// the serialiser FSM draining a byte FIFO.
module port_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [31:0] TX_DATA_ADDR = DEF_TX_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxSerial,
    output logic        TxBusy
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q;

    logic        hit_data;
    logic        hit_status;
    logic        wr_data;
    logic        rd_status;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] status;
    logic        baud_end;
    logic        unused_wdata;

    assign hit_data     = (Address == TX_DATA_ADDR);
    assign hit_status   = (Address == STATUS_ADDR);
    assign Hit          = hit_data || hit_status;
    assign wr_data      = MemWrite && hit_data;
    assign rd_status    = MemRead && hit_status;
    assign unused_wdata = ^WriteData[31:8];

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A store that hits a full FIFO sets overflow even if a status read clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (wr_data && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (rd_status) begin
            ovf_q <= 1'b0;
        end
    end

    always_comb begin
        status        = '0;
        status[BUSY]  = TxBusy;
        status[EMPTY] = fifo_empty;
        status[FULL]  = fifo_full;
        status[OVF]   = ovf_q;
        ReadData      = hit_status ? status : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d carries the level of the next bit so the line comes straight off a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
                tx_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign TxSerial = tx_q;
    assign TxBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_port_uart_tx;

    localparam logic [31:0] TX_ADDR  = 32'h1001_0024;
    localparam logic [31:0] ST_ADDR  = 32'h1001_0028;
    localparam logic [31:0] OTH_ADDR = 32'h1001_0000;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic        TxSerial;
    logic        TxBusy;

    int total = 0;
    int bad   = 0;

    port_uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .TxSerial  (TxSerial),
        .TxBusy    (TxBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        Address = ST_ADDR;
        #1;
        chk(tag, 64'(ReadData), 64'(exp));
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (TxSerial !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (TxBusy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < budget), 64'd1);
    endtask

    // Entered at the first sample where the start bit is low.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0]  frame;
        logic [39:0] exp_line;
        logic [39:0] line;
        logic [39:0] busy;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            exp_line[i] = frame[i / 4];
            line[i]     = TxSerial;
            busy[i]     = TxBusy;
            tick();
        end
        chk({tag, "_line"}, 64'(line), 64'(exp_line));
        chk({tag, "_busy"}, 64'(busy), {24'd0, {40{1'b1}}});
        chk({tag, "_end_tx"}, 64'(TxSerial), 64'd1);
        chk({tag, "_end_busy"}, 64'(TxBusy), 64'd0);
    endtask

    task automatic count_lows(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (TxSerial !== 1'b1) lows++;
            tick();
        end
        chk(tag, 64'(lows), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        #2;
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_tx", 64'(TxSerial), 64'd1);
        chk("rst_busy", 64'(TxBusy), 64'd0);
        reset = 1'b1;
        tick();

        read_status("rst_status", 32'h2);
        chk("hit_status", 64'(Hit), 64'd1);
        Address = OTH_ADDR;
        #1;
        chk("hit_other", 64'(Hit), 64'd0);
        chk("rd_other", 64'(ReadData), 64'd0);
        Address = TX_ADDR;
        #1;
        chk("hit_data", 64'(Hit), 64'd1);
        chk("rd_data", 64'(ReadData), 64'd0);

        // Single frame
        store(TX_ADDR, 32'hFFFF_FF55);
        chk("pre_fall", 64'(TxSerial), 64'd1);
        wait_fall(n);
        chk("fall_lat", 64'(n), 64'd1);
        check_frame("f55", 8'h55);

        // Burst, full FIFO and overflow
        for (int i = 1; i <= 5; i++) store(TX_ADDR, 32'(i));
        read_status("full_busy", 32'h5);
        store(TX_ADDR, 32'h6);
        read_status("ovf_set", 32'hD);
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        read_status("ovf_clr", 32'h5);
        wait_idle("drain1", 60);
        for (int b = 2; b <= 5; b++) begin
            wait_fall(n);
            chk($sformatf("gap_%0d", b), 64'(n), 64'd1);
            check_frame($sformatf("fb%0d", b), 8'(b));
        end
        read_status("drained", 32'h2);

        // Back-to-back frames with one idle cycle between
        tick();
        store(TX_ADDR, 32'hA5);
        store(TX_ADDR, 32'h3C);
        chk("fall2", 64'(TxSerial), 64'd0);
        check_frame("fA5", 8'hA5);
        wait_fall(n);
        chk("gap_a5_3c", 64'(n), 64'd1);
        check_frame("f3C", 8'h3C);
        read_status("idle4", 32'h2);

        // Reset during DATA bit 3 with bytes queued
        tick();
        store(TX_ADDR, 32'hF0);
        store(TX_ADDR, 32'h11);
        store(TX_ADDR, 32'h22);
        repeat (18) tick();
        chk("pre_rst_low", 64'(TxSerial), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_async_tx", 64'(TxSerial), 64'd1);
        chk("rst_async_busy", 64'(TxBusy), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        read_status("post_rst", 32'h2);
        count_lows("quiet_rst", 50);
        read_status("post_rst_end", 32'h2);

        // Stores to non-data addresses are ignored
        store(ST_ADDR, 32'h41);
        store(OTH_ADDR, 32'h42);
        read_status("ign_status", 32'h2);
        count_lows("quiet_ign", 50);
        read_status("ign_end", 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
